// File: rtl/fp_add_arbiter_pkg.sv
// Shared types and constants for the FP32 adder sequencer.
// Imported by the interface, the arbiter and the top.
package fp_add_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam int DATA_WIDTH_DEF = 32;

    // Index width that never collapses to zero bits.
    function automatic int clog2_safe(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Requester and adder-side signals of the FP32 adder sequencer.
// slave = sequencer view, master = requesters/adder view.
interface fp_add_arbiter_if
    import fp_add_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_op_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_op_b;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          add_start;
    logic [DATA_WIDTH-1:0]         add_op_a;
    logic [DATA_WIDTH-1:0]         add_op_b;
    logic                          add_done;
    logic [DATA_WIDTH-1:0]         add_result;

    modport slave (
        input  req_valid, req_op_a, req_op_b, rsp_ready,
        input  add_done, add_result,
        output req_ready, rsp_valid, rsp_data,
        output add_start, add_op_a, add_op_b
    );

    modport master (
        output req_valid, req_op_a, req_op_b, rsp_ready,
        output add_done, add_result,
        input  req_ready, rsp_valid, rsp_data,
        input  add_start, add_op_a, add_op_b
    );
endinterface

// File: rtl/fp_add_arbiter_rr.sv
// Combinational round-robin picker: first valid at or above ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter
    import fp_add_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]             valid,
    input  logic [clog2_safe(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]             grant,
    output logic [clog2_safe(NUM_REQ)-1:0] grant_idx,
    output logic                           any_valid
);
    localparam int ID_W = clog2_safe(NUM_REQ);

    int              pos;
    logic [ID_W-1:0] sel;
    logic            found;

    // Scan from ptr upward and take the first asserted valid.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        sel       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            sel = ID_W'(pos);
            if (!found && valid[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

    assign any_valid = |valid;

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one multi-cycle FP32 adder among NUM_REQ requesters:
// round-robin grant, start pulse, bounded wait, per-requester response.
module fp_add_arbiter
    import fp_add_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                           s00_axi_aclk,
    input  logic                           s00_axi_areset,
    fp_add_arbiter_if.slave                bus,
    output logic                           busy,
    output logic [clog2_safe(NUM_REQ)-1:0] grant_id,
    output logic                           err_timeout,
    input  logic                           err_clear,
    output logic [CNT_WIDTH-1:0]           op_count
);
    localparam int ID_W = clog2_safe(NUM_REQ);
    localparam int TW   = clog2_safe(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

    state_t state, state_n;

    logic [ID_W-1:0]       ptr;
    logic [TW-1:0]         wait_cnt;
    logic [NUM_REQ-1:0]    arb_grant;
    logic [ID_W-1:0]       arb_idx;
    logic                  arb_any;
    logic [NUM_REQ-1:0]    gid_hot;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic                  req_fire;
    logic                  done_hit;
    logic                  to_hit;
    logic                  rsp_fire;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .valid    (bus.req_valid),
        .ptr      (ptr),
        .grant    (arb_grant),
        .grant_idx(arb_idx),
        .any_valid(arb_any)
    );

    // Operand mux driven by the one-hot winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_a = bus.req_op_a[i*DATA_WIDTH +: DATA_WIDTH];
                sel_b = bus.req_op_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic; add_done only counts while in WAIT.
    always_comb begin
        state_n  = state;
        req_fire = 1'b0;
        done_hit = 1'b0;
        to_hit   = 1'b0;
        rsp_fire = 1'b0;
        unique case (state)
            IDLE: begin
                if (arb_any && !s00_axi_areset) begin
                    req_fire = 1'b1;
                    state_n  = ISSUE;
                end
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (bus.add_done) begin
                    done_hit = 1'b1;
                    state_n  = RESP;
                end else if (wait_cnt == TO_LAST) begin
                    to_hit  = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready[grant_id]) begin
                    rsp_fire = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs; ready is held low while reset is asserted.
    always_comb begin
        gid_hot           = '0;
        gid_hot[grant_id] = 1'b1;
        bus.req_ready = (state == IDLE && !s00_axi_areset) ? arb_grant : '0;
        bus.rsp_valid = (state == RESP) ? gid_hot : '0;
    end

    assign bus.add_start = (state == ISSUE);
    assign busy          = (state != IDLE);

    // State register.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) state <= IDLE;
        else                state <= state_n;
    end

    // Capture operands and winner on the request handshake.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            bus.add_op_a <= '0;
            bus.add_op_b <= '0;
            grant_id     <= '0;
        end else if (req_fire) begin
            bus.add_op_a <= sel_a;
            bus.add_op_b <= sel_b;
            grant_id     <= arb_idx;
        end
    end

    // Wait counter: cleared on issue, counts each WAIT cycle.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset)      wait_cnt <= '0;
        else if (state == ISSUE) wait_cnt <= '0;
        else if (state == WAIT)  wait_cnt <= wait_cnt + TW'(1);
    end

    // Result register: adder sum, or qNaN when the wait expires.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset)     bus.rsp_data <= '0;
        else if (done_hit) bus.rsp_data <= bus.add_result;
        else if (to_hit)   bus.rsp_data <= DATA_WIDTH'(FP32_QNAN);
    end

    // Rotate priority past the served requester and count completions.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            ptr      <= '0;
            op_count <= '0;
        end else if (rsp_fire) begin
            ptr      <= (grant_id == ID_LAST) ? '0 : grant_id + ID_W'(1);
            op_count <= op_count + CNT_WIDTH'(1);
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset)  err_timeout <= 1'b0;
        else if (to_hit)     err_timeout <= 1'b1;
        else if (err_clear)  err_timeout <= 1'b0;
    end

endmodule
